// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-I subset core with one shared memory port.
// Each instruction walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB]; illegal encodings park in HALT.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halt,
    output logic [CNT_W-1:0]  instr_count
);
    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;

    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2a;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      alu_q, alu_d;
    logic [31:0]      mdr_q, mdr_d;
    logic [31:0]      target_q, target_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic [31:0]      rf_q [32];
    logic [31:0]      rf_d [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] sext_imm, alu_r, ls_addr;
    logic        legal, retire;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
    assign ls_addr  = a_q + sext_imm;

    always_comb begin
        alu_r = '0;
        legal = 1'b0;
        case (funct)
            FnAdd:   alu_r = a_q + b_q;
            FnSub:   alu_r = a_q - b_q;
            FnAnd:   alu_r = a_q & b_q;
            FnOr:    alu_r = a_q | b_q;
            FnSlt:   alu_r = {31'b0, $signed(a_q) < $signed(b_q)};
            FnSll:   alu_r = b_q << shamt;
            default: alu_r = '0;
        endcase
        case (opcode)
            OpRtype:                       legal = funct inside {FnSll, FnAdd, FnSub, FnAnd, FnOr,
                                                                 FnSlt};
            OpJ, OpBeq, OpAddi, OpLw, OpSw: legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        a_d           = a_q;
        b_d           = b_q;
        alu_d         = alu_q;
        mdr_d         = mdr_q;
        target_d      = target_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = pc_q[ADDR_W-1:0];
        mem_wdata     = b_q;
        retire        = 1'b0;
        rf_we         = 1'b0;
        rf_waddr      = '0;
        rf_wdata      = '0;

        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d      = (rs == 5'd0) ? 32'h0 : rf_q[rs];
                b_d      = (rt == 5'd0) ? 32'h0 : rf_q[rt];
                target_d = pc_q + {sext_imm[29:0], 2'b00};
                state_d  = legal ? StExec : StHalt;
            end
            StExec: begin
                case (opcode)
                    OpRtype: begin
                        alu_d   = alu_r;
                        state_d = StWb;
                    end
                    OpAddi: begin
                        alu_d   = a_q + sext_imm;
                        state_d = StWb;
                    end
                    OpLw, OpSw: begin
                        alu_d   = ls_addr;
                        // Misaligned accesses never reach the bus.
                        state_d = (ls_addr[1:0] != 2'b00) ? StHalt : StMem;
                    end
                    OpBeq: begin
                        if (a_q == b_q) pc_d = target_q;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    OpJ: begin
                        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    default: state_d = StHalt;
                endcase
            end
            StMem: begin
                mem_req   = 1'b1;
                mem_we    = (opcode == OpSw);
                mem_addr  = alu_q[ADDR_W-1:0];
                mem_wdata = b_q;
                if (mem_ready) begin
                    if (opcode == OpSw) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
                case (opcode)
                    OpRtype: begin
                        rf_waddr = rd;
                        rf_wdata = alu_q;
                    end
                    OpLw: begin
                        rf_waddr = rt;
                        rf_wdata = mdr_q;
                    end
                    default: begin
                        rf_waddr = rt;
                        rf_wdata = alu_q;
                    end
                endcase
            end
            StHalt: state_d = StHalt;
            default: state_d = StHalt;
        endcase

        instr_count_d = instr_count_q + CNT_W'(retire);
    end

    always_comb begin
        rf_d = rf_q;
        if (rf_we) rf_d[rf_waddr] = rf_wdata;
        rf_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            alu_q         <= '0;
            mdr_q         <= '0;
            target_q      <= '0;
            instr_count_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            a_q           <= a_d;
            b_q           <= b_d;
            alu_q         <= alu_d;
            mdr_q         <= mdr_d;
            target_q      <= target_d;
            instr_count_q <= instr_count_d;
            rf_q          <= rf_d;
        end
    end

    assign halt        = (state_q == StHalt);
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: programs run from a wait-state memory model; stores are
// checked against a scoreboard of expected (addr, data) pairs, timing against cycle counts.
module tb_mips_multicycle;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, halt;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, instr_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem  [256];
    logic [31:0] prog [256];
    logic        load_en = 1'b0;
    int unsigned wait_cycles = 0;
    int unsigned wcnt = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;
    st_t exp_q[$];

    localparam logic [5:0] OpJ = 6'h02, OpBeq = 6'h04, OpAddi = 6'h08, OpLw = 6'h23, OpSw = 6'h2b;

    mips_multicycle dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .halt        (halt),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    assign mem_ready = mem_req && (wcnt >= wait_cycles);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (load_en) mem <= prog;
        else if (!rst && mem_req && mem_we && mem_ready) mem[mem_addr[9:2]] <= mem_wdata;
        if (rst || !mem_req || mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required bench completion");
        $fatal(1);
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // One clock step; a store handshake visible now completes on the coming edge.
    task automatic tick();
        st_t e;
        if (!rst && mem_req && mem_we && mem_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL store_unexpected: got addr=%h data=%h, required no store",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL store: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic push_store(input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 32'hFFFF_FFFF;
    endtask

    task automatic apply_reset(input int unsigned wc, input int n);
        exp_q.delete();
        rst         = 1'b1;
        load_en     = 1'b1;
        wait_cycles = wc;
        repeat (n) tick();
        load_en = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic wait_fetch(input logic [31:0] addr, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === addr) && cyc < 300);
    endtask

    task automatic wait_halt(output int cyc);
        cyc = 0;
        while (halt !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        clear_prog();
        prog[0] = enc_i(OpAddi, 0, 1, 16'd5);
        apply_reset(0, 4);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_fetch: got req=%b we=%b addr=%h, required req=1 we=0 addr=0",
                     mem_req, mem_we, mem_addr);
        end
        checks++;
        if (halt !== 1'b0) begin
            errors++;
            $display("FAIL reset_halt: got %b, required 0", halt);
        end
        checks++;
        if (instr_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_count: got %0d, required 0", instr_count);
        end
    endtask

    task automatic test_alu();
        int cyc;
        clear_prog();
        prog[0]  = enc_i(OpAddi, 0, 1, 16'd5);
        prog[1]  = enc_i(OpAddi, 0, 2, 16'd7);
        prog[2]  = enc_r(1, 2, 3, 0, 6'h20);
        prog[3]  = enc_r(1, 2, 4, 0, 6'h22);
        prog[4]  = enc_r(1, 2, 5, 0, 6'h24);
        prog[5]  = enc_r(1, 2, 6, 0, 6'h25);
        prog[6]  = enc_r(4, 1, 7, 0, 6'h2a);
        prog[7]  = enc_r(0, 2, 8, 4, 6'h00);
        prog[8]  = enc_i(OpAddi, 0, 9, 16'hFFFF);
        prog[9]  = enc_i(OpAddi, 9, 10, 16'd2);
        prog[10] = enc_i(OpAddi, 0, 0, 16'd9);
        prog[11] = enc_r(1, 4, 12, 0, 6'h2a);
        prog[12] = enc_i(OpSw, 0, 3, 16'h100);
        prog[13] = enc_i(OpSw, 0, 4, 16'h104);
        prog[14] = enc_i(OpSw, 0, 5, 16'h108);
        prog[15] = enc_i(OpSw, 0, 6, 16'h10C);
        prog[16] = enc_i(OpSw, 0, 7, 16'h110);
        prog[17] = enc_i(OpSw, 0, 8, 16'h114);
        prog[18] = enc_i(OpSw, 0, 10, 16'h118);
        prog[19] = enc_i(OpSw, 0, 0, 16'h11C);
        prog[20] = enc_i(OpSw, 0, 12, 16'h120);
        apply_reset(0, 2);
        push_store(32'h100, 32'd12);
        push_store(32'h104, 32'hFFFF_FFFE);
        push_store(32'h108, 32'd5);
        push_store(32'h10C, 32'd7);
        push_store(32'h110, 32'd1);
        push_store(32'h114, 32'h70);
        push_store(32'h118, 32'd1);
        push_store(32'h11C, 32'd0);
        push_store(32'h120, 32'd0);
        repeat (12) tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0C || instr_count !== 32'd3) begin
            errors++;
            $display("FAIL alu_12cyc: got req=%b pc=%h count=%0d, required req=1 pc=0c count=3",
                     mem_req, mem_addr, instr_count);
        end
        wait_halt(cyc);
        checks++;
        if (halt !== 1'b1 || exp_q.size() != 0 || instr_count !== 32'd21) begin
            errors++;
            $display("FAIL alu_end: got halt=%b pending=%0d count=%0d, required 1 0 21",
                     halt, exp_q.size(), instr_count);
        end
    endtask

    task automatic test_mem_wait();
        int cyc, we_cycles, bad;
        clear_prog();
        prog[0]  = enc_i(OpAddi, 0, 3, 16'd12);
        prog[1]  = {OpJ, 26'h10};
        prog[16] = enc_i(OpSw, 0, 3, 16'h8);
        prog[17] = enc_i(OpLw, 0, 4, 16'h8);
        prog[18] = enc_i(OpSw, 0, 4, 16'h200);
        apply_reset(3, 2);
        push_store(32'h8, 32'd12);
        push_store(32'h200, 32'd12);
        wait_fetch(32'h40, cyc);
        checks++;
        if (cyc != 13) begin
            errors++;
            $display("FAIL wait_to_0x40: got %0d cycles, required 13", cyc);
        end
        cyc = 0;
        we_cycles = 0;
        bad = 0;
        do begin
            tick();
            cyc++;
            if (mem_req === 1'b1 && mem_we === 1'b1) begin
                we_cycles++;
                if (mem_addr !== 32'h8 || mem_wdata !== 32'd12) bad++;
            end
        end while (!(mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 32'h44) && cyc < 300);
        checks++;
        if (cyc != 10 || we_cycles != 4 || bad != 0) begin
            errors++;
            $display("FAIL sw_wait: got cycles=%0d store_cycles=%0d unstable=%0d, required 10 4 0",
                     cyc, we_cycles, bad);
        end
        wait_fetch(32'h48, cyc);
        checks++;
        if (cyc != 11) begin
            errors++;
            $display("FAIL lw_wait: got %0d cycles, required 11", cyc);
        end
        wait_halt(cyc);
        checks++;
        if (halt !== 1'b1 || exp_q.size() != 0 || instr_count !== 32'd5) begin
            errors++;
            $display("FAIL mem_end: got halt=%b pending=%0d count=%0d, required 1 0 5",
                     halt, exp_q.size(), instr_count);
        end
    endtask

    task automatic test_branch();
        int cyc;
        logic [31:0] exp_addr [5];
        int          exp_cyc  [5];
        clear_prog();
        prog[0]  = enc_i(OpAddi, 0, 1, 16'd3);
        prog[1]  = enc_i(OpAddi, 0, 2, 16'd4);
        prog[2]  = 32'h0;
        prog[3]  = 32'h0;
        prog[4]  = enc_i(OpBeq, 1, 1, 16'd2);
        prog[7]  = enc_i(OpBeq, 1, 2, 16'd5);
        prog[8]  = {OpJ, 26'h40};
        prog[64] = enc_i(OpBeq, 1, 1, 16'hFFC8);
        prog[9]  = enc_i(OpSw, 0, 2, 16'h180);
        exp_addr = '{32'h10, 32'h1C, 32'h20, 32'h100, 32'h24};
        exp_cyc  = '{16, 3, 3, 3, 3};
        apply_reset(0, 2);
        push_store(32'h180, 32'd4);
        for (int i = 0; i < 5; i++) begin
            wait_fetch(exp_addr[i], cyc);
            checks++;
            if (cyc != exp_cyc[i]) begin
                errors++;
                $display("FAIL branch_fetch_%h: got %0d cycles, required %0d",
                         exp_addr[i], cyc, exp_cyc[i]);
            end
        end
        wait_halt(cyc);
        checks++;
        if (halt !== 1'b1 || exp_q.size() != 0 || instr_count !== 32'd9) begin
            errors++;
            $display("FAIL branch_end: got halt=%b pending=%0d count=%0d, required 1 0 9",
                     halt, exp_q.size(), instr_count);
        end
    endtask

    task automatic test_halt();
        int cyc;
        clear_prog();
        prog[0] = {OpJ, 26'h8};
        prog[8] = 32'hFC00_0000;
        apply_reset(0, 2);
        wait_fetch(32'h20, cyc);
        tick();
        checks++;
        if (halt !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_decode: got halt=%b req=%b, required 0 0", halt, mem_req);
        end
        tick();
        checks++;
        if (halt !== 1'b1 || mem_req !== 1'b0 || instr_count !== 32'd1) begin
            errors++;
            $display("FAIL halt_enter: got halt=%b req=%b count=%0d, required 1 0 1",
                     halt, mem_req, instr_count);
        end
        repeat (5) tick();
        checks++;
        if (halt !== 1'b1 || mem_req !== 1'b0 || instr_count !== 32'd1) begin
            errors++;
            $display("FAIL halt_hold: got halt=%b req=%b count=%0d, required 1 0 1",
                     halt, mem_req, instr_count);
        end
        clear_prog();
        prog[0] = enc_r(1, 2, 3, 0, 6'h21);
        apply_reset(0, 2);
        checks++;
        if (halt !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL halt_reset: got halt=%b req=%b addr=%h, required 0 1 0",
                     halt, mem_req, mem_addr);
        end
        wait_halt(cyc);
        checks++;
        if (cyc != 2 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL bad_funct: got %0d cycles count=%0d, required 2 0", cyc, instr_count);
        end
    endtask

    task automatic test_unaligned();
        int cyc, bad;
        for (int k = 0; k < 2; k++) begin
            clear_prog();
            prog[0] = enc_i(OpAddi, 0, 1, 16'd2);
            prog[1] = (k == 0) ? enc_i(OpLw, 1, 2, 16'd0) : enc_i(OpSw, 0, 1, 16'd2);
            apply_reset(0, 2);
            cyc = 0;
            bad = 0;
            while (halt !== 1'b1 && cyc < 300) begin
                tick();
                cyc++;
                if (mem_req === 1'b1 && mem_addr === 32'h2) bad++;
            end
            checks++;
            if (cyc != 7 || bad != 0 || instr_count !== 32'd1) begin
                errors++;
                $display("FAIL unaligned_%0d: got cycles=%0d requests=%0d count=%0d, required 7 0 1",
                         k, cyc, bad, instr_count);
            end
        end
    endtask

    task automatic test_reset_in_mem();
        int cyc;
        clear_prog();
        prog[0] = enc_i(OpAddi, 0, 1, 16'h55);
        prog[1] = enc_i(OpSw, 0, 1, 16'h80);
        apply_reset(0, 2);
        wait_fetch(32'h4, cyc);
        tick();
        wait_cycles = 100;
        tick();
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL mem_stall: got req=%b we=%b addr=%h, required 1 1 80",
                     mem_req, mem_we, mem_addr);
        end
        clear_prog();
        prog[0] = enc_i(OpSw, 0, 1, 16'h84);
        apply_reset(0, 2);
        push_store(32'h84, 32'h0);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0 || halt !== 1'b0 ||
            instr_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_from_mem: got req=%b we=%b addr=%h halt=%b count=%0d, required 1 0 0 0 0",
                     mem_req, mem_we, mem_addr, halt, instr_count);
        end
        wait_halt(cyc);
        checks++;
        if (exp_q.size() != 0 || instr_count !== 32'd1) begin
            errors++;
            $display("FAIL reset_rf: got pending=%0d count=%0d, required 0 1",
                     exp_q.size(), instr_count);
        end
    endtask

    task automatic test_count_wrap();
        int cyc;
        clear_prog();
        prog[0] = enc_i(OpAddi, 0, 0, 16'd1);
        prog[1] = enc_i(OpSw, 0, 0, 16'h90);
        apply_reset(0, 2);
        force dut.instr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count_q;
        tick();
        checks++;
        if (instr_count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL count_preload: got %h, required ffffffff", instr_count);
        end
        repeat (3) tick();
        checks++;
        if (instr_count !== 32'h0) begin
            errors++;
            $display("FAIL count_wrap: got %h, required 00000000", instr_count);
        end
        push_store(32'h90, 32'h0);
        wait_halt(cyc);
        checks++;
        if (exp_q.size() != 0 || instr_count !== 32'd1) begin
            errors++;
            $display("FAIL r0_write: got pending=%0d count=%0d, required 0 1",
                     exp_q.size(), instr_count);
        end
    endtask

    initial begin
        clear_prog();
        @(negedge clk);
        test_reset();
        test_alu();
        test_mem_wait();
        test_branch();
        test_halt();
        test_unaligned();
        test_reset_in_mem();
        test_count_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
